// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch port and a data port.
// Define ARB_RR_EN for round-robin arbitration; the default is D priority with an I starvation guard.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_adr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_in,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall
);

  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, RSP_I, RSP_D} state_t;

  state_t state;
  logic   grant_d;

`ifdef ARB_RR_EN
  logic last_grant_d;

  always_comb begin
    grant_d = d_req;
    if (inst_req && d_req) grant_d = !last_grant_d;
  end
`else
  logic [2:0] starve_cnt;

  // D wins a tie unless it has already taken STARVE_MAX grants while I waited
  always_comb begin
    grant_d = d_req;
    if (inst_req && d_req) grant_d = (starve_cnt != 3'(STARVE_MAX));
  end
`endif

  assign stall = (inst_req & ~inst_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      inst      <= '0;
      data_in   <= '0;
      inst_ack  <= 1'b0;
      d_ack     <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_d <= 1'b0;
`else
      starve_cnt   <= 3'd0;
`endif
    end else begin
      inst_ack <= 1'b0;
      d_ack    <= 1'b0;
      case (state)
        IDLE: begin
`ifdef ARB_RR_EN
          if (inst_req || d_req) last_grant_d <= grant_d;
`else
          if (!inst_req || !grant_d) starve_cnt <= 3'd0;
          else if (starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
`endif
          if (inst_req || d_req) begin
            mem_req <= 1'b1;
            if (grant_d) begin
              state     <= GNT_D;
              mem_adr   <= data_adr;
              mem_we    <= d_we;
              mem_wdata <= data_out;
            end else begin
              state     <= GNT_I;
              mem_adr   <= inst_adr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end
        GNT_I: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            inst     <= mem_rdata;
            inst_ack <= 1'b1;
            state    <= RSP_I;
          end
        end
        GNT_D: begin
          // a write still acks, but data_in keeps the last read value
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) data_in <= mem_rdata;
            d_ack   <= 1'b1;
            state   <= RSP_D;
          end
        end
        RSP_I, RSP_D: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model
// of the arbiter's grant rules and a bench-side memory.
module tb_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_adr;
  logic [DATA_W-1:0] inst;
  logic              inst_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic              d_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall;

  int checks = 0;
  int passes = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_adr(inst_adr), .inst(inst), .inst_ack(inst_ack),
    .d_req(d_req), .d_we(d_we), .data_adr(data_adr), .data_out(data_out),
    .data_in(data_in), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge
  task automatic do_reset();
    rst = 1'b0; inst_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    inst_adr = '0; data_adr = '0; data_out = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int acks = 0;
    do_reset();
    inst_req = 1'b1; inst_adr = 32'h4; d_req = 1'b1; d_we = 1'b0; data_adr = 32'h8;
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      @(negedge clk);
      if (inst_ack === 1'b1) begin acks++; inst_req = 1'b0; end
      if (d_ack === 1'b1) begin acks++; d_req = 1'b0; end
    end
    checks++;
    if (acks != 2) $display("[TB] FAIL rst_warmup_acks got=%0d exp=2", acks); else passes++;
    rst = 1'b0; inst_req = 1'b1; d_req = 1'b1; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, inst_ack, d_ack} !== 4'b0000)
      $display("[TB] FAIL rst_ctrl got=%b exp=0000", {mem_req, mem_we, inst_ack, d_ack});
    else passes++;
    checks++;
    if (mem_adr !== '0) $display("[TB] FAIL rst_mem_adr got=%h exp=0", mem_adr); else passes++;
    checks++;
    if (mem_wdata !== '0) $display("[TB] FAIL rst_mem_wdata got=%h exp=0", mem_wdata); else passes++;
    checks++;
    if (inst !== '0) $display("[TB] FAIL rst_inst got=%h exp=0", inst); else passes++;
    checks++;
    if (data_in !== '0) $display("[TB] FAIL rst_data_in got=%h exp=0", data_in); else passes++;
    rst = 1'b1; inst_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    inst_req = 1'b1; inst_adr = 32'h10; mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++;
    if ({stall, mem_req} !== 2'b10) $display("[TB] FAIL fetch_c1 stall,mem_req got=%b exp=10", {stall, mem_req});
    else passes++;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_adr} !== {1'b1, 1'b0, 32'h10})
      $display("[TB] FAIL fetch_c2_bus got=%b/%b/%h exp=1/0/00000010", mem_req, mem_we, mem_adr);
    else passes++;
    checks++;
    if ({stall, inst_ack} !== 2'b10) $display("[TB] FAIL fetch_c2 stall,ack got=%b exp=10", {stall, inst_ack});
    else passes++;
    mem_ready = 1'b1; mem_rdata = 32'h8C220004;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    checks++;
    if ({inst_ack, mem_req, stall} !== 3'b100)
      $display("[TB] FAIL fetch_c3 ack,mem_req,stall got=%b exp=100", {inst_ack, mem_req, stall});
    else passes++;
    checks++;
    if (inst !== 32'h8C220004) $display("[TB] FAIL fetch_data got=%h exp=8c220004", inst); else passes++;
    inst_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({inst_ack, mem_req} !== 2'b00) $display("[TB] FAIL fetch_c4 got=%b exp=00", {inst_ack, mem_req});
    else passes++;
  endtask

  task automatic test_priority();
    logic [ADDR_W-1:0] got [8];
    int g = 0;
    int cnt = 0;
    bit last_d = 1'b0;
    bit exp_d;
    rst = 1'b0; inst_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    inst_adr = 32'h100; data_adr = 32'h200; data_out = '0; mem_ready = 1'b1; mem_rdata = 32'h55;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 60 && g < 8; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin got[g] = mem_adr; g++; end
    end
    inst_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    if (g < 8) begin
      checks++;
      $display("[TB] FAIL prio_timeout grants got=%0d exp=8", g);
    end
    for (int i = 0; i < g; i++) begin
`ifdef ARB_RR_EN
      exp_d = !last_d;
      last_d = exp_d;
`else
      exp_d = (cnt != STARVE_MAX);
      cnt = exp_d ? cnt + 1 : 0;
`endif
      checks++;
      if (got[i] !== (exp_d ? 32'h200 : 32'h100))
        $display("[TB] FAIL prio_grant%0d got=%h exp=%h", i, got[i], exp_d ? 32'h200 : 32'h100);
      else passes++;
    end
  endtask

  task automatic test_write_hold();
    int n = 0;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; data_adr = 32'h24; mem_ready = 1'b1; mem_rdata = 32'h13579BDF;
    while (d_ack !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if ({d_ack, data_in} !== {1'b1, 32'h13579BDF})
      $display("[TB] FAIL wr_pre_read got=%b/%h exp=1/13579bdf", d_ack, data_in);
    else passes++;
    d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; data_adr = 32'h20; data_out = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_adr, mem_wdata, d_ack} !== {1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0})
        $display("[TB] FAIL wr_hold_c%0d got=%b/%b/%h/%h/%b exp=1/1/00000020/deadbeef/0",
                 c, mem_req, mem_we, mem_adr, mem_wdata, d_ack);
      else passes++;
      mem_ready = (c == 5); mem_rdata = $urandom;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if ({d_ack, mem_req} !== 2'b10) $display("[TB] FAIL wr_ack got=%b exp=10", {d_ack, mem_req}); else passes++;
    checks++;
    if (data_in !== 32'h13579BDF) $display("[TB] FAIL wr_data_in_hold got=%h exp=13579bdf", data_in);
    else passes++;
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b0) $display("[TB] FAIL wr_ack_once got=%b exp=0", d_ack); else passes++;
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    logic [DATA_W-1:0] ack_data = '0;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; data_adr = 32'h40; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) $display("[TB] FAIL abort_gnt got=%b exp=1", mem_req); else passes++;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    checks++;
    if ({mem_req, d_ack, stall} !== 3'b001)
      $display("[TB] FAIL abort_rst mem_req,ack,stall got=%b exp=001", {mem_req, d_ack, stall});
    else passes++;
    checks++;
    if (data_in !== '0) $display("[TB] FAIL abort_data_in got=%h exp=0", data_in); else passes++;
    rst = 1'b1; mem_rdata = 32'h12345678;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_ack === 1'b1) begin acks++; ack_data = data_in; d_req = 1'b0; end
    end
    mem_ready = 1'b0;
    checks++;
    if (acks != 1) $display("[TB] FAIL abort_reissue_acks got=%0d exp=1", acks); else passes++;
    checks++;
    if (ack_data !== 32'h12345678) $display("[TB] FAIL abort_reissue_data got=%h exp=12345678", ack_data);
    else passes++;
  endtask

  task automatic test_random();
    int phase = 0;
    int cur;
    int d_streak = 0;
    bit last_d = 1'b0;
    bit who_d = 1'b0, m_we = 1'b0, d_wins, just_i, just_d, exp_iack, exp_dack;
    logic [ADDR_W-1:0] m_adr = '0;
    logic [DATA_W-1:0] m_wdata = '0, exp_data = '0, last_rd = '0;
    logic [DATA_W-1:0] mem_model [16];
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      exp_iack = (phase == 2) && !who_d;
      exp_dack = (phase == 2) && who_d;
      checks++;
      if (mem_req !== (phase == 1)) $display("[TB] FAIL rnd_mem_req c%0d got=%b exp=%b", c, mem_req, phase == 1);
      else passes++;
      if (phase == 1) begin
        checks++;
        if ({mem_we, mem_adr} !== {m_we, m_adr})
          $display("[TB] FAIL rnd_bus c%0d got=%b/%h exp=%b/%h", c, mem_we, mem_adr, m_we, m_adr);
        else passes++;
        if (who_d && m_we) begin
          checks++;
          if (mem_wdata !== m_wdata) $display("[TB] FAIL rnd_wdata c%0d got=%h exp=%h", c, mem_wdata, m_wdata);
          else passes++;
        end
      end
      checks++;
      if ({inst_ack, d_ack} !== {exp_iack, exp_dack})
        $display("[TB] FAIL rnd_acks c%0d got=%b exp=%b", c, {inst_ack, d_ack}, {exp_iack, exp_dack});
      else passes++;
      if (exp_iack) begin
        checks++;
        if (inst !== exp_data) $display("[TB] FAIL rnd_inst c%0d got=%h exp=%h", c, inst, exp_data);
        else passes++;
      end
      if (exp_dack) begin
        checks++;
        if (data_in !== (m_we ? last_rd : exp_data))
          $display("[TB] FAIL rnd_data_in c%0d got=%h exp=%h", c, data_in, m_we ? last_rd : exp_data);
        else passes++;
      end
      checks++;
      if (stall !== ((inst_req && !exp_iack) || (d_req && !exp_dack)))
        $display("[TB] FAIL rnd_stall c%0d got=%b exp=%b", c, stall, (inst_req && !exp_iack) || (d_req && !exp_dack));
      else passes++;

      cur = phase;
      just_i = 1'b0; just_d = 1'b0;
      mem_ready = 1'b0; mem_rdata = $urandom;
      if (cur == 1 && $urandom_range(0, 2) == 0) begin
        mem_ready = 1'b1;
        mem_rdata = mem_model[m_adr[5:2]];
        exp_data  = mem_model[m_adr[5:2]];
        if (who_d && m_we) mem_model[m_adr[5:2]] = m_wdata;
        phase = 2;
      end else if (cur == 2) begin
        if (who_d) begin
          d_req = 1'b0; just_d = 1'b1;
          if (!m_we) last_rd = exp_data;
        end else begin
          inst_req = 1'b0; just_i = 1'b1;
        end
        phase = 0;
      end
      if (!inst_req && !just_i && $urandom_range(0, 2) == 0) begin
        inst_req = 1'b1; inst_adr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!d_req && !just_d && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        data_adr = 32'($urandom_range(0, 15)) << 2; data_out = $urandom;
      end
      if (cur == 0) begin
        d_wins = d_req;
        if (inst_req && d_req) begin
`ifdef ARB_RR_EN
          d_wins = !last_d;
`else
          d_wins = (d_streak != STARVE_MAX);
`endif
        end
        if (!inst_req || !d_wins) d_streak = 0;
        else if (d_streak < 7) d_streak++;
        if (inst_req || d_req) begin
          last_d = d_wins; who_d = d_wins; phase = 1;
          if (d_wins) begin m_adr = data_adr; m_we = d_we; m_wdata = data_out; end
          else begin m_adr = inst_adr; m_we = 1'b0; end
        end
      end
      @(negedge clk);
    end
    inst_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    $display("[TB] mem_arbiter bench start");
    test_reset();
    test_fetch();
    test_priority();
    test_write_hold();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
